// File: rtl/math_divider_seq_8bit.sv
// Sequential unsigned 8-bit restoring divider sharing one 8-bit subtractor across 8 iterations.
// Optional macro MATH_DIV_EARLY_EXIT_EN finishes in one cycle when dividend < divisor.

module math_subtractor_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       borrow_i,
  output logic [7:0] diff_o,
  output logic       error_o
);

  logic [8:0] borrow;

  assign borrow[0] = borrow_i;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign diff_o[i]     = a_i[i] ^ b_i[i] ^ borrow[i];
    assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
  end

  // Borrow out of the MSB means a_i < b_i + borrow_i.
  assign error_o = borrow[8];

endmodule

module math_divider_seq_8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] dividend_i,
  input  logic [7:0] divisor_i,
  output logic [7:0] quotient_o,
  output logic [7:0] remainder_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q;
  logic [7:0] q_q;
  logic [7:0] d_q;
  logic [7:0] r_q;
  logic [2:0] count_q;
  logic [7:0] quotient_q;
  logic [7:0] remainder_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;

  logic [7:0] trial;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic [7:0] sub_diff;
  logic       sub_err;
  logic [7:0] r_d;
  logic [7:0] q_d;
  logic       unused_r_msb;

  // R stays below 2^i after i iterations, so its MSB is always zero when shifted out.
  assign trial        = {r_q[6:0], q_q[7]};
  assign unused_r_msb = r_q[7];

`ifdef MATH_DIV_EARLY_EXIT_EN
  assign sub_a = (state_q == StCalc) ? trial : dividend_i;
  assign sub_b = (state_q == StCalc) ? d_q : divisor_i;
`else
  assign sub_a = trial;
  assign sub_b = d_q;
`endif

  math_subtractor_8bit u_sub (
    .a_i      (sub_a),
    .b_i      (sub_b),
    .borrow_i (1'b0),
    .diff_o   (sub_diff),
    .error_o  (sub_err)
  );

  always_comb begin
    r_d = sub_err ? trial : sub_diff;
    q_d = {q_q[6:0], ~sub_err};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      q_q         <= 8'd0;
      d_q         <= 8'd0;
      r_q         <= 8'd0;
      count_q     <= 3'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (start_i) begin
            if (divisor_i == 8'd0) begin
              quotient_q  <= 8'hFF;
              remainder_q <= dividend_i;
              error_q     <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StDone;
`ifdef MATH_DIV_EARLY_EXIT_EN
            end else if (sub_err) begin
              quotient_q  <= 8'd0;
              remainder_q <= dividend_i;
              error_q     <= 1'b0;
              busy_q      <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StDone;
`endif
            end else begin
              q_q     <= dividend_i;
              d_q     <= divisor_i;
              r_q     <= 8'd0;
              count_q <= 3'd0;
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          r_q     <= r_d;
          q_q     <= q_d;
          count_q <= count_q + 3'd1;
          if (count_q == 3'd7) begin
            quotient_q  <= q_d;
            remainder_q <= r_d;
            done_q      <= 1'b1;
            count_q     <= 3'd0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
